// File: rtl/aes_dec_pkg.sv
// Shared state encoding and round constants for the AES decrypt round controller.
package aes_dec_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        INIT   = 3'd1,
        PHASE0 = 3'd2,
        PHASE1 = 3'd3,
        FINISH = 3'd4
    } state_e;

    localparam int unsigned NUM_ROUNDS   = 10;
    localparam logic [3:0]  LAST_KEY_IDX = 4'd10;

endpackage

// File: rtl/aes_decrypt_controller.sv
// AES-128 decrypt round sequencer: INIT, then 10 rounds of PHASE0/PHASE1, then a FINISH pulse.
// Optional AES_DEC_START_QUEUE_EN latches one start request made while busy and chains it after FINISH.
module aes_decrypt_controller
    import aes_dec_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       busy,
    output logic       initAdd,
    output logic       phase,
    output logic [3:0] roundCount,
    output logic [3:0] keyIndex,
    output logic       lastRound,
    output logic       done
);

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    state_e     state_q, state_d;
    logic [3:0] round_q, round_d;
    logic       launch;

`ifdef AES_DEC_START_QUEUE_EN
    logic pending_q, pending_d;

    assign launch = pending_q | start;

    // Entering INIT consumes the request; a start while already pending is dropped.
    always_comb begin
        pending_d = pending_q;
        if (state_d == INIT) begin
            pending_d = 1'b0;
        end else if (start && busy) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
        end
    end
`else
    assign launch = 1'b0;
`endif

    always_comb begin
        state_d = IDLE;
        round_d = 4'd1;
        case (state_q)
            IDLE:    state_d = start ? INIT : IDLE;
            INIT:    state_d = PHASE0;
            PHASE0: begin
                state_d = PHASE1;
                round_d = round_q;
            end
            PHASE1: begin
                // Round 10 holds its count into FINISH rather than wrapping to 11.
                if (round_q == LAST_ROUND) begin
                    state_d = FINISH;
                    round_d = round_q;
                end else begin
                    state_d = PHASE0;
                    round_d = round_q + 4'd1;
                end
            end
            FINISH:  state_d = launch ? INIT : IDLE;
            default: state_d = start ? INIT : IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            round_q <= 4'd1;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
        end
    end

    always_comb begin
        busy     = 1'b0;
        initAdd  = 1'b0;
        phase    = 1'b0;
        done     = 1'b0;
        keyIndex = '0;
        case (state_q)
            INIT: begin
                busy     = 1'b1;
                initAdd  = 1'b1;
                keyIndex = LAST_KEY_IDX;
            end
            PHASE0: begin
                busy     = 1'b1;
                keyIndex = LAST_KEY_IDX - round_q;
            end
            PHASE1: begin
                busy     = 1'b1;
                phase    = 1'b1;
                keyIndex = LAST_KEY_IDX - round_q;
            end
            FINISH: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    assign roundCount = round_q;
    assign lastRound  = (round_q == LAST_ROUND);

endmodule

// File: tb/tb_aes_decrypt_controller.sv
// Self-checking bench for aes_decrypt_controller; reference model is a per-block cycle timeline.
// Expectations follow AES_DEC_START_QUEUE_EN when the bench is built with that macro.
module tb_aes_decrypt_controller;

`ifdef AES_DEC_START_QUEUE_EN
    localparam bit QEN = 1'b1;
`else
    localparam bit QEN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       busy, initAdd, phase, lastRound, done;
    logic [3:0] roundCount, keyIndex;
    logic [12:0] obs;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // Model: m_t = cycles since the block's start was sampled (0 = INIT .. 21 = FINISH), -1 when idle.
    int m_t    = -1;
    bit m_pend = 1'b0;

    aes_decrypt_controller dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .busy       (busy),
        .initAdd    (initAdd),
        .phase      (phase),
        .roundCount (roundCount),
        .keyIndex   (keyIndex),
        .lastRound  (lastRound),
        .done       (done)
    );

    always #5 clk = ~clk;

    assign obs = {busy, initAdd, phase, lastRound, done, roundCount, keyIndex};

    function automatic logic [12:0] expect_out(input int t);
        int   rnd;
        int   ki;
        logic b, ia, ph, lr, dn;
        b  = (t >= 0);
        ia = (t == 0);
        ph = (t >= 1 && t <= 20 && (t % 2) == 0);
        dn = (t == 21);
        if (t >= 1 && t <= 20)  rnd = (t + 1) / 2;
        else if (t == 21)       rnd = 10;
        else                    rnd = 1;
        if (t == 0)             ki = 10;
        else if (t >= 1 && t <= 20) ki = 10 - rnd;
        else                    ki = 0;
        lr = (rnd == 10);
        return {b, ia, ph, lr, dn, 4'(rnd), 4'(ki)};
    endfunction

    function automatic void model_step(input logic s, input logic rst);
        if (rst) begin
            m_t    = -1;
            m_pend = 1'b0;
        end else if (m_t < 0) begin
            m_t = s ? 0 : -1;
        end else if (m_t == 21) begin
            m_t    = (QEN && (m_pend || s)) ? 0 : -1;
            m_pend = 1'b0;
        end else begin
            m_t = m_t + 1;
            if (QEN && s) m_pend = 1'b1;
        end
    endfunction

    task automatic advance(input logic s);
        start = s;
        @(posedge clk);
        model_step(s, reset);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start = 1'b0;
        #2;
        n_cmp++;
        if (obs !== expect_out(-1)) begin
            n_bad++;
            $display("FAIL reset_async: got %h want %h", obs, expect_out(-1));
        end
        for (int i = 0; i < 3; i++) begin
            advance(1'b1);
            n_cmp++;
            if (obs !== expect_out(m_t)) begin
                n_bad++;
                $display("FAIL reset_held cyc %0d: got %h want %h", i, obs, expect_out(m_t));
            end
        end
        #3 reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            advance(1'b0);
            n_cmp++;
            if (obs !== expect_out(m_t)) begin
                n_bad++;
                $display("FAIL idle_hold cyc %0d: got %h want %h", i, obs, expect_out(m_t));
            end
        end
    endtask

    task automatic test_single_block;
        int n_done  = 0;
        int done_at = -1;
        advance(1'b1);
        n_cmp++;
        if (obs !== expect_out(m_t)) begin
            n_bad++;
            $display("FAIL single_init: got %h want %h", obs, expect_out(m_t));
        end
        for (int i = 1; i <= 23; i++) begin
            advance(1'b0);
            n_cmp++;
            if (obs !== expect_out(m_t)) begin
                n_bad++;
                $display("FAIL single_block cyc %0d: got %h want %h", i, obs, expect_out(m_t));
            end
            if (done === 1'b1) begin
                n_done++;
                done_at = i;
            end
        end
        n_cmp++;
        if (n_done !== 1 || done_at !== 21) begin
            n_bad++;
            $display("FAIL single_done: got %0d pulses last at E%0d, want 1 at E21", n_done, done_at);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL single_idle_after: busy got %b want 0", busy);
        end
    endtask

    task automatic test_start_while_busy;
        int dones[$];
        int want[$];
        want = QEN ? '{21, 43} : '{21};
        for (int i = 0; i <= 46; i++) begin
            advance((i == 0) || (i == 5));
            n_cmp++;
            if (obs !== expect_out(m_t)) begin
                n_bad++;
                $display("FAIL busy_start cyc %0d: got %h want %h", i, obs, expect_out(m_t));
            end
            if (done === 1'b1) dones.push_back(i);
        end
        n_cmp++;
        if (dones !== want) begin
            n_bad++;
            $display("FAIL busy_start_dones: got %0d pulses (first E%0d) want %0d pulses",
                     dones.size(), (dones.size() > 0) ? dones[0] : -1, want.size());
        end
    endtask

    task automatic test_reset_mid_round;
        int guard;
        int n_done  = 0;
        int done_at = -1;
        advance(1'b1);
        guard = 0;
        while (m_t != 10 && guard < 30) begin
            advance(1'b0);
            guard++;
            n_cmp++;
            if (obs !== expect_out(m_t)) begin
                n_bad++;
                $display("FAIL midround_run cyc %0d: got %h want %h", guard, obs, expect_out(m_t));
            end
        end
        n_cmp++;
        if (roundCount !== 4'd5 || phase !== 1'b1) begin
            n_bad++;
            $display("FAIL midround_reach: round %0d phase %b want round 5 phase 1", roundCount, phase);
        end
        #3 reset = 1'b1;
        #1;
        n_cmp++;
        if (obs !== expect_out(-1)) begin
            n_bad++;
            $display("FAIL midround_async_reset: got %h want %h", obs, expect_out(-1));
        end
        advance(1'b0);
        #3 reset = 1'b0;
        advance(1'b1);
        for (int i = 1; i <= 23; i++) begin
            advance(1'b0);
            n_cmp++;
            if (obs !== expect_out(m_t)) begin
                n_bad++;
                $display("FAIL midround_rerun cyc %0d: got %h want %h", i, obs, expect_out(m_t));
            end
            if (done === 1'b1) begin
                n_done++;
                done_at = i;
            end
        end
        n_cmp++;
        if (n_done !== 1 || done_at !== 21) begin
            n_bad++;
            $display("FAIL midround_rerun_done: got %0d pulses last at E%0d, want 1 at E21", n_done, done_at);
        end
    endtask

    task automatic test_back_to_back;
        int n_done    = 0;
        int busy_lows = 0;
        for (int i = 0; i <= 65; i++) begin
            advance(1'b1);
            n_cmp++;
            if (obs !== expect_out(m_t)) begin
                n_bad++;
                $display("FAIL held_start cyc %0d: got %h want %h", i, obs, expect_out(m_t));
            end
            if (done === 1'b1) n_done++;
            if (busy !== 1'b1) busy_lows++;
        end
        n_cmp++;
        if (n_done !== (QEN ? 3 : 2) || busy_lows !== (QEN ? 0 : 2)) begin
            n_bad++;
            $display("FAIL held_start_period: got %0d dones %0d idle cycles want %0d dones %0d idle cycles",
                     n_done, busy_lows, QEN ? 3 : 2, QEN ? 0 : 2);
        end
        for (int i = 0; i < 50; i++) begin
            advance(1'b0);
            n_cmp++;
            if (obs !== expect_out(m_t)) begin
                n_bad++;
                $display("FAIL held_drain cyc %0d: got %h want %h", i, obs, expect_out(m_t));
            end
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                reset = 1'b1;
                #1;
                n_cmp++;
                if (obs !== expect_out(-1)) begin
                    n_bad++;
                    $display("FAIL random_reset cyc %0d: got %h want %h", i, obs, expect_out(-1));
                end
                advance(1'b0);
                reset = 1'b0;
            end else begin
                advance($urandom_range(0, 5) == 0);
                n_cmp++;
                if (obs !== expect_out(m_t)) begin
                    n_bad++;
                    $display("FAIL random cyc %0d: got %h want %h (t=%0d)", i, obs, expect_out(m_t), m_t);
                end
            end
        end
        for (int i = 0; i < 50; i++) begin
            advance(1'b0);
            n_cmp++;
            if (obs !== expect_out(m_t)) begin
                n_bad++;
                $display("FAIL random_drain cyc %0d: got %h want %h", i, obs, expect_out(m_t));
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        test_reset();
        test_single_block();
        test_start_while_busy();
        test_reset_mid_round();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/aes_decrypt_controller.md
AES_DECRYPT_CONTROLLER -- requirements
Module: aes_decrypt_controller

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to decrypt a new block; sampled on rising clk.
REQ-005 busy  output  1  high in every state except IDLE.
REQ-006 initAdd  output  1  high in INIT: initial AddRoundKey with key 10.
REQ-007 phase  output  1  0 = Phase0 (InvShiftRows/InvSubBytes), 1 = Phase1 (AddRoundKey, then InvMixColumns).
REQ-008 roundCount  output  4  current round index, 1..10.
REQ-009 keyIndex  output  4  round-key index the datapath uses this cycle.
REQ-010 lastRound  output  1  high when roundCount==10; datapath skips InvMixColumns.
REQ-011 done  output  1  one-cycle pulse: plaintext valid.

Function
REQ-012 SHALL use states IDLE, INIT, PHASE0, PHASE1 and FINISH.
REQ-013 IDLE SHALL go to INIT when start=1; otherwise it stays in IDLE.
REQ-014 INIT SHALL go to PHASE0 and last exactly 1 cycle.
REQ-015 PHASE0 SHALL go to PHASE1.
REQ-016 PHASE1 SHALL go to FINISH if roundCount==10; otherwise it goes to PHASE0.
REQ-017 FINISH SHALL go to IDLE, except as given in REQ-027.
REQ-018 roundCount SHALL be forced to 1 in IDLE and INIT.
REQ-019 roundCount SHALL increment by 1 on each clk edge leaving PHASE1 and never exceed 10.
REQ-020 keyIndex SHALL be 10 in INIT and 10-roundCount in PHASE0/PHASE1 (9..0); 4-bit unsigned, 0 in IDLE/FINISH.
REQ-021 phase, initAdd, done and busy SHALL be pure combinational decodes of state, with no registered lag.
REQ-022 Latency: if start is sampled at edge E0, done SHALL be high between edges E21 and E22 (INIT 1 cycle + 20 phase cycles), then state returns to IDLE.
REQ-023 Without the queue feature, start SHALL be ignored while busy.

Reset
REQ-024 Reset SHALL force state=IDLE and roundCount=1 immediately, including mid-operation.
REQ-025 Under reset, busy, initAdd, phase, lastRound, done and keyIndex SHALL all be 0, and any pending request is cleared.
REQ-026 After reset release, operation SHALL resume on the first rising clk with start=1.

Configuration
REQ-027 With macro AES_DEC_START_QUEUE_EN defined:
  - a one-deep pendingStart flag is set by start=1 while busy;
  - FINISH goes to INIT, not IDLE, if pendingStart=1 or start=1 in FINISH;
  - the flag clears on entering INIT;
  - back-to-back blocks run with a 22-cycle period and no IDLE gap;
  - start while the flag is already set is dropped.
REQ-028 Without the macro, pendingStart SHALL not exist and the behaviour is exactly REQ-013..REQ-023.

Structure
REQ-029 Package aes_dec_pkg SHALL hold:
  - 3-bit state encoding: IDLE=0, INIT=1, PHASE0=2, PHASE1=3, FINISH=4;
  - NUM_ROUNDS=10;
  - LAST_KEY_IDX=10.
REQ-030 The block SHALL be one FSM plus counter, with no sub-module; state encodings 5..7 decode to IDLE.

Verification
REQ-031 Single block: start pulsed 1 cycle in IDLE -> initAdd=1 with keyIndex=10; keyIndex sequence 9,9,8,8,...,0,0; done after E21; busy low after E22.
REQ-032 Round 10: in PHASE1 with roundCount=10 -> lastRound=1, keyIndex=0, next state FINISH, and roundCount never reads 11.
REQ-033 Reset mid-round: reset asserted during PHASE1 of round 5 -> all outputs 0 and roundCount=1 the same cycle; a later start gives the full 22-cycle sequence.
REQ-034 Start while busy, macro off: start at E5 -> ignored; a single done pulse, then IDLE.
REQ-035 Start while busy, macro on: start at E5 -> done at E21, INIT at E22, second done at E43; exactly two done pulses.
REQ-036 Start held high continuously, macro on: done repeats every 22 cycles and busy never drops.
